// File: rtl/tstamp_pkg.sv
// Shared constants and types for the timestamp arbiter and its sub-blocks.
package tstamp_pkg;

    localparam logic OP_START = 1'b0;
    localparam logic OP_STOP  = 1'b1;

    localparam int unsigned CNT_W_DEFAULT = 64;

    typedef enum logic {
        StIdle,
        StRunning
    } ch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests that are also eligible.
// ptr_i is the index where the search starts; ptr_o is its post-grant value.
module rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    elig_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [PtrW-1:0] ptr_o
);

    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        gnt_o = '0;
        ptr_o = ptr_i;
        idx   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PtrW'((32'(ptr_i) + off) % N);
            if (!found && req_i[idx] && elig_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_o      = PtrW'((32'(idx) + 1) % N);
            end
        end
    end

endmodule

// File: rtl/tstamp_arbiter.sv
// Shares one free-running counter among NUM_REQ START/STOP requesters.
// Define TSTAMP_MAXHOLD_EN to add the per-channel maximum-elapsed output rsp_max.
module tstamp_arbiter
    import tstamp_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned CNT_W   = CNT_W_DEFAULT,
    localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CNT_W-1:0]   counter_in,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               rsp_valid,
    output logic [IdW-1:0]     rsp_id,
    output logic [CNT_W-1:0]   rsp_elapsed,
    output logic               rsp_err,
`ifdef TSTAMP_MAXHOLD_EN
    output logic [CNT_W-1:0]   rsp_max,
`endif
    input  logic               rsp_ready
);

    ch_state_e          state_q [NUM_REQ];
    ch_state_e          state_d [NUM_REQ];
    logic [CNT_W-1:0]   start_q [NUM_REQ];
    logic [CNT_W-1:0]   start_d [NUM_REQ];
    logic [IdW-1:0]     ptr_q, ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IdW-1:0]     rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   rsp_elapsed_q, rsp_elapsed_d;
    logic               rsp_err_q, rsp_err_d;

    logic               slot_free;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [IdW-1:0]     gnt_idx;
    logic [CNT_W-1:0]   elapsed;

`ifdef TSTAMP_MAXHOLD_EN
    logic [CNT_W-1:0]   max_q [NUM_REQ];
    logic [CNT_W-1:0]   max_d [NUM_REQ];
    logic [CNT_W-1:0]   rsp_max_q, rsp_max_d;

    assign rsp_max = rsp_max_q;
`endif

    // A STOP may only win when its response has somewhere to go this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = (req_op[i] == OP_START) || slot_free;
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req_i  (req_valid),
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .ptr_o  (ptr_d)
    );

    assign req_ready = reset ? '0 : gnt;

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        rsp_valid_d   = rsp_valid_q && !rsp_ready;
        rsp_id_d      = rsp_id_q;
        rsp_elapsed_d = rsp_elapsed_q;
        rsp_err_d     = rsp_err_q;
        gnt_idx       = '0;
        elapsed       = '0;
`ifdef TSTAMP_MAXHOLD_EN
        max_d         = max_q;
        rsp_max_d     = rsp_max_q;
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = IdW'(i);
        end

        if (|gnt) begin
            if (req_op[gnt_idx] == OP_START) begin
                start_d[gnt_idx] = counter_in;
                state_d[gnt_idx] = StRunning;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = gnt_idx;
                if (state_q[gnt_idx] == StRunning) begin
                    elapsed          = counter_in - start_q[gnt_idx];
                    rsp_elapsed_d    = elapsed;
                    rsp_err_d        = 1'b0;
                    state_d[gnt_idx] = StIdle;
`ifdef TSTAMP_MAXHOLD_EN
                    max_d[gnt_idx] = (elapsed > max_q[gnt_idx]) ? elapsed : max_q[gnt_idx];
                    rsp_max_d      = max_d[gnt_idx];
`endif
                end else begin
                    rsp_elapsed_d = '0;
                    rsp_err_d     = 1'b1;
`ifdef TSTAMP_MAXHOLD_EN
                    rsp_max_d     = max_q[gnt_idx];
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= StIdle;
                start_q[i] <= '0;
`ifdef TSTAMP_MAXHOLD_EN
                max_q[i]   <= '0;
`endif
            end
            ptr_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_elapsed_q <= '0;
            rsp_err_q     <= 1'b0;
`ifdef TSTAMP_MAXHOLD_EN
            rsp_max_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            ptr_q         <= ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_elapsed_q <= rsp_elapsed_d;
            rsp_err_q     <= rsp_err_d;
`ifdef TSTAMP_MAXHOLD_EN
            max_q         <= max_d;
            rsp_max_q     <= rsp_max_d;
`endif
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_elapsed = rsp_elapsed_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_tstamp_arbiter.sv
// Scoreboard bench for tstamp_arbiter; expected responses queued as STOPs are issued.
module tb_tstamp_arbiter;
    import tstamp_pkg::*;

`ifdef TSTAMP_MAXHOLD_EN
    localparam bit MaxEn = 1'b1;
`else
    localparam bit MaxEn = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] el;
        logic        err;
        logic [63:0] mx;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] counter_in;
    logic [3:0]  req_valid;
    logic [3:0]  req_op;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_elapsed;
    logic        rsp_err;
    logic [63:0] rsp_max_w;
    logic        rsp_ready;

    int compared   = 0;
    int mismatched = 0;
    rsp_t exp_q[$];
    rsp_t got_q[$];

    always #5 clock = ~clock;

    tstamp_arbiter #(
        .NUM_REQ (4),
        .CNT_W   (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .counter_in  (counter_in),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_elapsed (rsp_elapsed),
        .rsp_err     (rsp_err),
`ifdef TSTAMP_MAXHOLD_EN
        .rsp_max     (rsp_max_w),
`endif
        .rsp_ready   (rsp_ready)
    );

`ifndef TSTAMP_MAXHOLD_EN
    assign rsp_max_w = '0;
`endif

    // Capture every consumed response.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            got_q.push_back('{rsp_id, rsp_elapsed, rsp_err, rsp_max_w});
        end
    end

    function automatic rsp_t mk(input int id, input logic [63:0] el, input logic err,
                                input logic [63:0] mx);
        rsp_t r;
        r.id  = 2'(id);
        r.el  = el;
        r.err = err;
        r.mx  = MaxEn ? mx : 64'd0;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Hold one command until granted; returns just after the granting edge.
    task automatic cmd(input int r, input logic op, input logic [63:0] cv);
        int n = 0;
        counter_in   = cv;
        req_op[r]    = op;
        req_valid[r] = 1'b1;
        forever begin
            @(negedge clock);
            if (req_ready[r]) break;
            n++;
            if (n > 20) begin
                compared++;
                mismatched++;
                $display("FAIL grant_timeout: req%0d op=%0d never granted, wanted a grant", r, op);
                break;
            end
        end
        step();
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 50) begin
            step();
            n++;
        end
        if (got_q.size() < exp_q.size()) begin
            compared++;
            mismatched++;
            $display("FAIL rsp_timeout: got %0d responses, wanted %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 4'hF;
        req_op     = 4'h0;
        rsp_ready  = 1'b1;
        counter_in = '0;
        step();
        @(negedge clock);
        compared++;
        if (req_ready !== 4'h0) begin
            mismatched++;
            $display("FAIL reset_ready: req_ready=%b, wanted 0000", req_ready);
        end
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid: rsp_valid=%b, wanted 0", rsp_valid);
        end
        compared++;
        if (rsp_id !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_id: rsp_id=%0d, wanted 0", rsp_id);
        end
        compared++;
        if (rsp_elapsed !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_elapsed: rsp_elapsed=%0d, wanted 0", rsp_elapsed);
        end
        compared++;
        if (rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_err: rsp_err=%b, wanted 0", rsp_err);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            want = 4'b0001 << (k % 4);
            @(negedge clock);
            compared++;
            if (req_ready !== want) begin
                mismatched++;
                $display("FAIL rr_grant%0d: req_ready=%b, wanted %b", k, req_ready, want);
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_basic();
        rsp_t e, g;
        cmd(0, OP_START, 64'd100);
        cmd(0, OP_STOP, 64'd350);
        exp_q.push_back(mk(0, 64'd250, 1'b0, 64'd250));
        compared++;
        if (rsp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_latency: rsp_valid=%b, wanted 1", rsp_valid);
        end
        wait_rsp();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL basic_rsp: got id=%0d el=%0d err=%0d max=%0d, wanted id=%0d el=%0d err=%0d max=%0d",
                         g.id, g.el, g.err, g.mx, e.id, e.el, e.err, e.mx);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_wrap();
        rsp_t e, g;
        cmd(1, OP_START, 64'hFFFF_FFFF_FFFF_FFF6);
        cmd(1, OP_STOP, 64'd5);
        exp_q.push_back(mk(1, 64'd15, 1'b0, 64'd15));
        wait_rsp();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL wrap_rsp: got id=%0d el=%0d err=%0d max=%0d, wanted id=%0d el=%0d err=%0d max=%0d",
                         g.id, g.el, g.err, g.mx, e.id, e.el, e.err, e.mx);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        rsp_t e, g;
        cmd(1, OP_START, 64'd1000);
        rsp_ready = 1'b0;
        cmd(0, OP_START, 64'd10);
        cmd(0, OP_STOP, 64'd40);
        exp_q.push_back(mk(0, 64'd30, 1'b0, 64'd250));
        counter_in   = 64'd1100;
        req_op[1]    = OP_STOP;
        req_op[2]    = OP_START;
        req_valid[1] = 1'b1;
        req_valid[2] = 1'b1;
        @(negedge clock);
        compared++;
        if (req_ready !== 4'b0100) begin
            mismatched++;
            $display("FAIL bp_skip: req_ready=%b, wanted 0100", req_ready);
        end
        step();
        req_valid[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            compared++;
            if (req_ready !== 4'b0000) begin
                mismatched++;
                $display("FAIL bp_blocked%0d: req_ready=%b, wanted 0000", k, req_ready);
            end
            compared++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_elapsed !== 64'd30) begin
                mismatched++;
                $display("FAIL bp_hold%0d: valid=%b id=%0d el=%0d, wanted 1/0/30",
                         k, rsp_valid, rsp_id, rsp_elapsed);
            end
            step();
        end
        rsp_ready  = 1'b1;
        counter_in = 64'd1200;
        @(negedge clock);
        compared++;
        if (req_ready !== 4'b0010) begin
            mismatched++;
            $display("FAIL bp_consume_grant: req_ready=%b, wanted 0010", req_ready);
        end
        exp_q.push_back(mk(1, 64'd200, 1'b0, 64'd200));
        step();
        req_valid[1] = 1'b0;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            mismatched++;
            $display("FAIL bp_no_bubble: valid=%b id=%0d, wanted 1/1", rsp_valid, rsp_id);
        end
        wait_rsp();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL bp_rsp: got id=%0d el=%0d err=%0d max=%0d, wanted id=%0d el=%0d err=%0d max=%0d",
                         g.id, g.el, g.err, g.mx, e.id, e.el, e.err, e.mx);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_err_restart();
        rsp_t e, g;
        cmd(3, OP_STOP, 64'd777);
        exp_q.push_back(mk(3, 64'd0, 1'b1, 64'd0));
        cmd(3, OP_START, 64'd500);
        cmd(3, OP_START, 64'd540);
        cmd(3, OP_STOP, 64'd600);
        exp_q.push_back(mk(3, 64'd60, 1'b0, 64'd60));
        wait_rsp();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL err_rsp: got id=%0d el=%0d err=%0d max=%0d, wanted id=%0d el=%0d err=%0d max=%0d",
                         g.id, g.el, g.err, g.mx, e.id, e.el, e.err, e.mx);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        rsp_t e, g;
        rsp_ready = 1'b0;
        cmd(0, OP_START, 64'd10);
        cmd(2, OP_STOP, 64'd1500);
        reset = 1'b1;
        step();
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_valid: rsp_valid=%b, wanted 0", rsp_valid);
        end
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        rsp_ready = 1'b1;
        cmd(0, OP_STOP, 64'd50);
        exp_q.push_back(mk(0, 64'd0, 1'b1, 64'd0));
        wait_rsp();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL midreset_rsp: got id=%0d el=%0d err=%0d max=%0d, wanted id=%0d el=%0d err=%0d max=%0d",
                         g.id, g.el, g.err, g.mx, e.id, e.el, e.err, e.mx);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_maxhold();
        rsp_t e, g;
        cmd(1, OP_START, 64'd0);
        cmd(1, OP_STOP, 64'd30);
        exp_q.push_back(mk(1, 64'd30, 1'b0, 64'd30));
        cmd(1, OP_START, 64'd100);
        cmd(1, OP_STOP, 64'd120);
        exp_q.push_back(mk(1, 64'd20, 1'b0, 64'd30));
        wait_rsp();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL max_rsp: got id=%0d el=%0d err=%0d max=%0d, wanted id=%0d el=%0d err=%0d max=%0d",
                         g.id, g.el, g.err, g.mx, e.id, e.el, e.err, e.mx);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        do_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_err_restart();
        test_reset_mid();
        test_maxhold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, wanted completion");
        $fatal(1, "watchdog");
    end

endmodule
